parity_lut_arbiter: RTL and testbench

- Shares one registered XOR-reduce stage (LUT feeding a flip-flop) among NUM_REQ requesters.
- Round-robin arbitration, one operand accepted per cycle, 1-cycle latency.
- The result is held in a single output register with valid/ready backpressure.
- Sits between several small producers and one shared LUT+FF parity resource in the FPGA fabric.

---
 rtl/parity_lut_arbiter.sv | 118 +++++++++++
 tb/tb_parity_lut_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_lut_arbiter.sv
// ----------------------------------------------------------------------------
// parity_lut_arbiter
//
// Shares one registered XOR-reduce stage (a LUT feeding a flip-flop) among
// NUM_REQ requesters. A round-robin arbiter accepts at most one operand per
// cycle. The parity of the accepted operand is registered together with the
// requester index. The result register has valid/ready backpressure.
//
// Parameters:
//   NUM_REQ  number of requesters (>= 2; need not be a power of two)
//   DATA_W   operand width per requester
//   ID_W     width of the requester index (derived)
//
// Ports:
//   clk         clock; all state updates on posedge
//   rst         synchronous active-high reset
//   req         per-requester request; held with stable data until granted
//   data        operands; requester k at [k*DATA_W +: DATA_W]
//   gnt         one-hot grant; operand k consumed on the edge where gnt[k]=1
//   res_valid   result register holds a result
//   res_ready   consumer accepts the result this cycle
//   res_parity  XOR-reduction of the granted operand
//   res_id      index of the requester that produced res_parity
//   res_count   (only with PARITY_LUT_ARBITER_CNT_EN) count of completed
//               result handshakes; 16 bits, wraps
//
// Build option:
//   PARITY_LUT_ARBITER_CNT_EN  adds the res_count port and its counter.
// ----------------------------------------------------------------------------
module parity_lut_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_parity,
    output logic [ID_W-1:0]           res_id
`ifdef PARITY_LUT_ARBITER_CNT_EN
    ,
    output logic [15:0]               res_count
`endif
);

    logic [ID_W-1:0]    rr_ptr;
    logic               accept;
    logic [NUM_REQ-1:0] par;
    logic [ID_W-1:0]    gnt_id;
    logic               found;
    logic [ID_W:0]      sum;
    logic [ID_W-1:0]    idx;

    // Per-requester parity; only the granted one is registered.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_par
        assign par[k] = ^data[k*DATA_W +: DATA_W];
    end

    // The slot can take a new result if it is empty or being drained now.
    assign accept = !res_valid || res_ready;

    // Round-robin search starting at rr_ptr. The index is computed with one
    // extra bit and folded back by a single subtraction, so non-power-of-two
    // NUM_REQ wraps correctly.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        if (!rst && accept) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
                if (sum >= (ID_W+1)'(NUM_REQ)) begin
                    sum = sum - (ID_W+1)'(NUM_REQ);
                end
                idx = sum[ID_W-1:0];
                if (!found && req[idx]) begin
                    found       = 1'b1;
                    gnt[idx]    = 1'b1;
                    gnt_id      = idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_parity <= 1'b0;
            res_id     <= '0;
            rr_ptr     <= '0;
        end else if (|gnt) begin
            // A grant also covers the drain-and-refill case.
            res_valid  <= 1'b1;
            res_parity <= par[gnt_id];
            res_id     <= gnt_id;
            rr_ptr     <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
        end else if (res_valid && res_ready) begin
            res_valid  <= 1'b0;
        end
    end

`ifdef PARITY_LUT_ARBITER_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            res_count <= '0;
        end else if (res_valid && res_ready) begin
            res_count <= res_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_parity_lut_arbiter.sv
// ----------------------------------------------------------------------------
// tb_parity_lut_arbiter
//
// Directed bench for parity_lut_arbiter. A 4-requester instance covers reset,
// single request, round-robin order, backpressure, drain+grant and reset
// mid-stream. A 3-requester instance covers the non-power-of-two wrap.
// The handshake counter is checked when PARITY_LUT_ARBITER_CNT_EN is defined.
// ----------------------------------------------------------------------------
module tb_parity_lut_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] data;
    logic [3:0]  gnt;
    logic        res_valid;
    logic        res_ready;
    logic        res_parity;
    logic [1:0]  res_id;
    logic [15:0] res_count;

    logic [2:0]  req3;
    logic [11:0] data3;
    logic [2:0]  gnt3;
    logic        res_valid3;
    logic        res_ready3;
    logic        res_parity3;
    logic [1:0]  res_id3;
    logic [15:0] res_count3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    parity_lut_arbiter #(.NUM_REQ(4), .DATA_W(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data       (data),
        .gnt        (gnt),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_parity (res_parity),
        .res_id     (res_id)
`ifdef PARITY_LUT_ARBITER_CNT_EN
        ,
        .res_count  (res_count)
`endif
    );

    parity_lut_arbiter #(.NUM_REQ(3), .DATA_W(4)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .req        (req3),
        .data       (data3),
        .gnt        (gnt3),
        .res_valid  (res_valid3),
        .res_ready  (res_ready3),
        .res_parity (res_parity3),
        .res_id     (res_id3)
`ifdef PARITY_LUT_ARBITER_CNT_EN
        ,
        .res_count  (res_count3)
`endif
    );

`ifndef PARITY_LUT_ARBITER_CNT_EN
    assign res_count  = 16'h0000;
    assign res_count3 = 16'h0000;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic       exp_par [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        rst        = 1'b1;
        req        = 4'b0000;
        data       = 16'h0000;
        res_ready  = 1'b0;
        req3       = 3'b000;
        data3      = 12'h731;
        res_ready3 = 1'b1;

        // Reset then idle
        tick();
        chk("rst_valid", res_valid, 0);
        chk("rst_parity", res_parity, 0);
        chk("rst_id", res_id, 0);
        chk("rst_gnt", gnt, 0);
        req = 4'b1111;
        #1;
        chk("rst_gnt_forced", gnt, 0);
        tick();
        chk("rst_valid2", res_valid, 0);
        chk("rst_gnt_forced2", gnt, 0);

        // Single request from requester 2, operand 1011
        rst       = 1'b0;
        req       = 4'b0100;
        data      = 16'h0B00;
        res_ready = 1'b1;
        #1;
        chk("single_gnt", gnt, 4'b0100);
        tick();
        req = 4'b0000;
        #1;
        chk("single_valid", res_valid, 1);
        chk("single_parity", res_parity, 1);
        chk("single_id", res_id, 2);
        chk("single_gnt_off", gnt, 0);
        // rr_ptr should now be 3
        req = 4'b1111;
        #1;
        chk("single_rrptr3", gnt, 4'b1000);
        req = 4'b0000;
        tick();
        chk("drain_valid", res_valid, 0);
        chk("drain_parity_hold", res_parity, 1);
        chk("drain_id_hold", res_id, 2);

        // Move rr_ptr to 0 via a grant to requester 3
        data = 16'h7310;
        req  = 4'b1000;
        #1;
        chk("r3_gnt", gnt, 4'b1000);
        tick();
        chk("r3_id", res_id, 3);
        chk("r3_parity", res_parity, 1);

        // Round-robin with all requesting
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rr_gnt%0d", i), gnt, exp_gnt[i]);
            tick();
            chk($sformatf("rr_valid%0d", i), res_valid, 1);
            chk($sformatf("rr_id%0d", i), res_id, exp_id[i]);
            chk($sformatf("rr_parity%0d", i), res_parity, exp_par[i]);
        end

        // Backpressure: result id0 pending, rr_ptr=1
        res_ready = 1'b0;
        #1;
        chk("bp_gnt", gnt, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_gnt%0d", i), gnt, 0);
            chk($sformatf("bp_valid%0d", i), res_valid, 1);
            chk($sformatf("bp_id%0d", i), res_id, 0);
            chk($sformatf("bp_parity%0d", i), res_parity, 0);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_gnt", gnt, 4'b0010);
        tick();
        chk("bp_release_valid", res_valid, 1);
        chk("bp_release_id", res_id, 1);
        chk("bp_release_parity", res_parity, 1);

        // Reset mid-stream with a pending result
        rst = 1'b1;
        #1;
        chk("midrst_gnt", gnt, 0);
        tick();
        chk("midrst_valid", res_valid, 0);
        chk("midrst_id", res_id, 0);
        chk("midrst_parity", res_parity, 0);
`ifdef PARITY_LUT_ARBITER_CNT_EN
        chk("midrst_count", res_count, 0);
`endif
        rst = 1'b0;
        #1;
        chk("midrst_rrptr0", gnt, 4'b0001);
        req = 4'b0000;

        // Non-power-of-two wrap on the 3-requester instance
        req3 = 3'b010;
        #1;
        chk("np2_gnt1", gnt3, 3'b010);
        tick();
        chk("np2_id1", res_id3, 1);
        chk("np2_parity1", res_parity3, 0);
        req3 = 3'b101;
        #1;
        chk("np2_gnt2", gnt3, 3'b100);
        tick();
        chk("np2_id2", res_id3, 2);
        chk("np2_parity2", res_parity3, 1);
        #1;
        chk("np2_gnt_wrap", gnt3, 3'b001);
        tick();
        chk("np2_id0", res_id3, 0);
        chk("np2_parity0", res_parity3, 1);
        req3 = 3'b110;
        #1;
        chk("np2_gnt_after_wrap", gnt3, 3'b010);
        req3 = 3'b000;
        tick();

`ifdef PARITY_LUT_ARBITER_CNT_EN
        // Handshake counter wrap: 65537 handshakes leave the count at 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("cnt_start", res_count, 0);
        req       = 4'b0001;
        data      = 16'h0001;
        res_ready = 1'b1;
        repeat (65538) tick();
        chk("cnt_wrap", res_count, 16'h0001);
        chk("cnt_valid", res_valid, 1);
        rst = 1'b1;
        tick();
        chk("cnt_rst_valid", res_valid, 0);
        chk("cnt_rst_count", res_count, 0);
        rst = 1'b0;
        req = 4'b0000;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
